// File: rtl/otter_uart_tx_mmio.sv
// OTTER IOBUS UART transmitter: CPU stores to TX_ADDR are queued in a byte FIFO
// and sent 8N1, LSB first. STATUS reports queue depth and flags for the CPU to poll.
module otter_uart_tx_mmio #(
  parameter int          CLK_RATE   = 50,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] TX_ADDR    = 32'h11000040,
  parameter logic [31:0] STAT_ADDR  = 32'h11000044
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] STATUS,
  output logic        STAT_HIT,
  output logic        TX
);

  localparam int DIV  = (CLK_RATE * 1000000 + BAUD / 2) / BAUD;
  localparam int BW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  localparam logic [BW-1:0]   BAUD_LAST = BW'(DIV - 1);
  localparam logic [BW-1:0]   BAUD_ONE  = BW'(1);
  localparam logic [PW-1:0]   PTR_ONE   = PW'(1);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_reg, state_next;
  logic [BW-1:0]   baud_reg, baud_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;
  logic            tx_reg, tx_next;
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNTW-1:0] count_reg, count_next;
  logic            ovf_reg, ovf_next;
  logic [7:0]      mem [FIFO_DEPTH];

  logic empty, full, pop, push_req, push_ok, ovf_set, ovf_clr, baud_last;
  logic [7:0] head;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_FULL);
  assign head      = mem[rd_ptr_reg];
  assign baud_last = (baud_reg == BAUD_LAST);

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_req = IOBUS_WR && (IOBUS_ADDR == TX_ADDR);
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;
  assign ovf_clr  = IOBUS_WR && (IOBUS_ADDR == STAT_ADDR) && IOBUS_OUT[2];

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (!empty) begin
          pop        = 1'b1;
          shift_next = head;
          state_next = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_reg == 3'd7) begin
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_next = '0;
          // Chain straight into the next frame so queued bytes leave with no idle gap.
          if (!empty) begin
            pop        = 1'b1;
            shift_next = head;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // TX is registered from the next-state view so the line never glitches.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop)
      count_next = count_reg + CNT_ONE;
    else if (!push_ok && pop)
      count_next = count_reg - CNT_ONE;
  end

  always_comb begin
    ovf_next = ovf_reg;
    if (ovf_set)
      ovf_next = 1'b1;
    else if (ovf_clr)
      ovf_next = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (push_ok)
      mem[wr_ptr_reg] <= IOBUS_OUT[7:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      tx_reg     <= 1'b1;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  assign TX       = tx_reg;
  assign STAT_HIT = (IOBUS_ADDR == STAT_ADDR);
  assign STATUS   = {{(24 - CNTW){1'b0}}, count_reg, 5'b0, ovf_reg, full,
                     (state_reg != IDLE) || !empty};

endmodule

// File: tb/tb_otter_uart_tx_mmio.sv
// Directed bench for otter_uart_tx_mmio at DIV=4: frame timing and bit order,
// back-to-back frames, overflow/clear, full push+pop, reset mid-frame, address decode.
module tb_otter_uart_tx_mmio;

  localparam logic [31:0] TX_ADDR   = 32'h11000040;
  localparam logic [31:0] STAT_ADDR = 32'h11000044;

  logic        CLK, RESET, IOBUS_WR, STAT_HIT, TX;
  logic [31:0] IOBUS_ADDR, IOBUS_OUT, STATUS;

  int total = 0;
  int bad   = 0;

  otter_uart_tx_mmio #(
    .CLK_RATE  (1),
    .BAUD      (250000),
    .FIFO_DEPTH(16),
    .TX_ADDR   (TX_ADDR),
    .STAT_ADDR (STAT_ADDR)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IOBUS_ADDR(IOBUS_ADDR),
    .IOBUS_OUT (IOBUS_OUT),
    .IOBUS_WR  (IOBUS_WR),
    .STATUS    (STATUS),
    .STAT_HIT  (STAT_HIT),
    .TX        (TX)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [31:0] d);
    IOBUS_WR   = wr;
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
  endtask

  // Called one negedge before the start bit is visible; samples every cycle of the frame.
  task automatic chk_frame(input logic [7:0] data, input string tag, input int exp_cnt,
                           input int first_i);
    logic [9:0] word;
    word = {1'b1, data, 1'b0};
    for (int i = first_i; i < 40; i++) begin
      @(negedge CLK);
      check({tag, "_tx"}, {31'b0, TX}, {31'b0, word[i / 4]});
      if (i == 1 && exp_cnt >= 0) begin
        check({tag, "_cnt"}, {8'b0, STATUS[31:8]}, 32'(exp_cnt));
        check({tag, "_busy"}, {31'b0, STATUS[0]}, 32'd1);
      end
    end
    $display("frame %s byte=%02h checked", tag, data);
  endtask

  initial begin
    RESET = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge CLK);
    check("rst_tx", {31'b0, TX}, 32'd1);
    check("rst_status", STATUS, 32'h0);
    RESET = 1'b0;

    // 1: single byte, TX falls two edges after the write
    @(negedge CLK); drive(1'b1, TX_ADDR, 32'hA5);
    @(negedge CLK); drive(1'b0, 32'h0, 32'h0);
    check("t1_pre_tx", {31'b0, TX}, 32'd1);
    chk_frame(8'hA5, "t1", 0, 0);
    @(negedge CLK);
    check("t1_idle_status", STATUS, 32'h0);
    check("t1_idle_tx", {31'b0, TX}, 32'd1);

    // 2: three pushes in consecutive cycles, contiguous frames
    fork
      begin
        @(negedge CLK); drive(1'b1, TX_ADDR, 32'h00);
        @(negedge CLK); drive(1'b1, TX_ADDR, 32'hFF);
        @(negedge CLK); drive(1'b1, TX_ADDR, 32'h55);
        @(negedge CLK); drive(1'b0, 32'h0, 32'h0);
      end
      begin
        repeat (2) @(negedge CLK);
        check("t2_pre_tx", {31'b0, TX}, 32'd1);
        chk_frame(8'h00, "t2a", 2, 0);
        chk_frame(8'hFF, "t2b", 1, 0);
        chk_frame(8'h55, "t2c", 0, 0);
      end
    join
    @(negedge CLK);
    check("t2_idle_status", STATUS, 32'h0);

    // 3: 18 pushes while frame 1 is in progress; 18th overflows
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK); drive(1'b1, TX_ADDR, 32'(i));
    end
    @(negedge CLK);
    check("t3_ovf_status", STATUS, 32'h0000_1007);
    drive(1'b1, STAT_ADDR, 32'h4);
    @(negedge CLK);
    drive(1'b0, 32'h0, 32'h0);
    check("t3_clr_status", STATUS, 32'h0000_1003);

    // 4: push lands on the same edge STOP pops the next byte
    repeat (21) @(negedge CLK);
    check("t4_stop_tx_a", {31'b0, TX}, 32'd1);
    @(negedge CLK);
    check("t4_stop_tx_b", {31'b0, TX}, 32'd1);
    drive(1'b1, TX_ADDR, 32'hAB);
    @(negedge CLK);
    drive(1'b0, 32'h0, 32'h0);
    check("t4_status", STATUS, 32'h0000_1003);
    check("t4_start_tx", {31'b0, TX}, 32'd0);
    chk_frame(8'h01, "t4_f01", 16, 1);
    for (int b = 2; b <= 16; b++)
      chk_frame(8'(b), "t4_fq", -1, 0);
    chk_frame(8'hAB, "t4_fab", 0, 0);
    @(negedge CLK);
    check("t4_idle_status", STATUS, 32'h0);

    // 5: reset during DATA bit 3 of 0x3C with five bytes queued
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK); drive(1'b1, TX_ADDR, (i == 0) ? 32'h3C : 32'(8'h10 + i));
    end
    @(negedge CLK); drive(1'b0, 32'h0, 32'h0);
    repeat (12) @(negedge CLK);
    check("t5_bit3_tx", {31'b0, TX}, 32'd1);
    check("t5_pre_status", STATUS, 32'h0000_0501);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    check("t5_rst_tx", {31'b0, TX}, 32'd1);
    check("t5_rst_status", STATUS, 32'h0);
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      check("t5_quiet_tx", {31'b0, TX}, 32'd1);
    end
    check("t5_end_status", STATUS, 32'h0);

    // 6: address decode
    @(negedge CLK); drive(1'b1, TX_ADDR + 32'd4, 32'hAA);
    #1 check("t6_hit_stat", {31'b0, STAT_HIT}, 32'd1);
    @(negedge CLK); drive(1'b1, TX_ADDR - 32'd4, 32'hAA);
    #1 check("t6_hit_below", {31'b0, STAT_HIT}, 32'd0);
    @(negedge CLK); drive(1'b0, TX_ADDR, 32'h0);
    #1 check("t6_hit_tx", {31'b0, STAT_HIT}, 32'd0);
    check("t6_status_a", STATUS, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("t6_tx_idle", {31'b0, TX}, 32'd1);
    end
    check("t6_status_b", STATUS, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
